// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between N_REQ requesters.
// A granted command runs through SETUP and ACCESS. Read data and error status
// go back to the requester that won the grant.
module apb_rr_master_arbiter #(
    parameter int N_REQ       = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [AW-1:0]       paddr,
    output logic [DW-1:0]       pwdata,
    input  logic [DW-1:0]       prdata,
    input  logic                pready,
    input  logic                pslverr
);

    // Pointer/owner width: at least one bit, even when there is a single requester.
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Timeout counter width. A disabled timeout still gets a one-bit counter, which never moves.
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [AW-1:0]      paddr_q, paddr_d;
    logic [DW-1:0]      pwdata_q, pwdata_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [PW:0]        idx_sum;
    logic               found;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      ptr_after_win;
    logic               timeout_hit;
    logic               arb_en;

    // Round-robin search: first valid requester starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_sum >= (PW+1)'(N_REQ)) begin
                idx_sum = idx_sum - (PW+1)'(N_REQ);
            end
            if (!found && req_valid[idx_sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx_sum[PW-1:0];
            end
        end
    end

    assign ptr_after_win = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    assign timeout_hit   = (TIMEOUT_CYC > 0) && (tcnt_q == TW'(TIMEOUT_CYC - 1));

    // Next-state logic: phase sequencing, completion/abort handling and grant decisions.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        tcnt_d      = tcnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        arb_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                tcnt_d    = '0;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : prdata;
                    rsp_err_d            = pslverr;
                    arb_en               = 1'b1;
                end else if (timeout_hit) begin
                    // Slave never answered: abort and report an error with no data.
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    arb_en               = 1'b1;
                end else if (TIMEOUT_CYC > 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // A winner in a completion cycle chains straight into the next SETUP.
        if (arb_en) begin
            if (found) begin
                state_d             = ST_SETUP;
                psel_d              = 1'b1;
                penable_d           = 1'b0;
                req_ready_d[winner] = 1'b1;
                ptr_d               = ptr_after_win;
                owner_d             = winner;
                pwrite_d            = req_write[winner];
                paddr_d             = req_addr[int'(winner)*AW +: AW];
                pwdata_d            = req_wdata[int'(winner)*DW +: DW];
            end else begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        end
    end

    // State and output registers. An asynchronous reset drops any transfer that is in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            tcnt_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            tcnt_q      <= tcnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter. Each table row gives the inputs for one cycle
// and the registered outputs expected after the next clock edge. Hand-written sequences
// cover reset at startup and reset in the middle of a transfer.
module tb_apb_rr_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_rr_master_arbiter #(
        .N_REQ       (N),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  wr;
        logic        rdy;
        logic        serr;
        logic [31:0] prd;
        logic        e_psel;
        logic        e_pen;
        logic [3:0]  e_rr;
        logic [3:0]  e_rsp;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] a_of(input int i);
        return 32'(16 * (i + 1));
    endfunction

    function automatic logic [31:0] w_of(input int i);
        return 32'(256 + i);
    endfunction

    function automatic logic [3:0] bit_of(input int i);
        return 4'(1 << i);
    endfunction

    function automatic void add(input logic [3:0] rv, input logic [3:0] wr,
                                input logic rdy, input logic serr, input logic [31:0] prd,
                                input logic ps, input logic pe,
                                input logic [3:0] rr, input logic [3:0] rsp,
                                input logic er, input logic [31:0] rd,
                                input logic [31:0] pa, input logic pw, input logic [31:0] pwd,
                                input string nm);
        vec_t v;
        v.rv = rv; v.wr = wr; v.rdy = rdy; v.serr = serr; v.prd = prd;
        v.e_psel = ps; v.e_pen = pe; v.e_rr = rr; v.e_rsp = rsp;
        v.e_err = er; v.e_rdata = rd; v.e_paddr = pa; v.e_pwrite = pw; v.e_pwdata = pwd;
        v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int g;
        int gn;

        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_of(i);
            req_wdata[i*DW +: DW] = w_of(i);
        end

        // ---- Reset state ----
        repeat (2) @(posedge pclk);
        #1;
        check("rst/psel",      32'(psel),      32'd0);
        check("rst/penable",   32'(penable),   32'd0);
        check("rst/pwrite",    32'(pwrite),    32'd0);
        check("rst/paddr",     paddr,          32'd0);
        check("rst/pwdata",    pwdata,         32'd0);
        check("rst/req_ready", 32'(req_ready), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata,      32'd0);
        check("rst/rsp_err",   32'(rsp_err),   32'd0);
        presetn = 1'b1;

        // ---- All four requesters issue writes at once; expect grants 0,1,2,3 back-to-back ----
        add(4'hF, 4'hF, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 32'h0, a_of(0), 1'b1, w_of(0), "b2b_g0");
        add(4'hE, 4'hE, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(0), 1'b1, w_of(0), "b2b_s0");
        add(4'hE, 4'hE, 1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 4'h2, 4'h1, 1'b0, 32'h0, a_of(1), 1'b1, w_of(1), "b2b_c0");
        add(4'hC, 4'hC, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(1), 1'b1, w_of(1), "b2b_s1");
        add(4'hC, 4'hC, 1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 4'h4, 4'h2, 1'b0, 32'h0, a_of(2), 1'b1, w_of(2), "b2b_c1");
        add(4'h8, 4'h8, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(2), 1'b1, w_of(2), "b2b_s2");
        add(4'h8, 4'h8, 1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 32'h0, a_of(3), 1'b1, w_of(3), "b2b_c2");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(3), 1'b1, w_of(3), "b2b_s3");
        add(4'h0, 4'h0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 32'h0, a_of(3), 1'b1, w_of(3), "b2b_c3");

        // ---- Single read from requester 0: psel at 1, penable at 2, rsp at 3 ----
        add(4'h1, 4'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 32'h0,         a_of(0), 1'b0, w_of(0), "rd_grant");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0,         a_of(0), 1'b0, w_of(0), "rd_setup");
        add(4'h0, 4'h0, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 32'hA5A5_0001, a_of(0), 1'b0, w_of(0), "rd_done");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0,         a_of(0), 1'b0, w_of(0), "rd_idle");

        // ---- Fairness: requesters 1 and 3 held valid; grants alternate 1,3 for 8 transfers ----
        add(4'hA, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, bit_of(1), 4'h0, 1'b0, 32'h0, a_of(1), 1'b0, w_of(1), "fair_g");
        for (int k = 0; k < 8; k++) begin
            g  = (k % 2 == 0) ? 1 : 3;
            gn = (k % 2 == 0) ? 3 : 1;
            add(4'hA, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(g), 1'b0, w_of(g), "fair_s");
            if (k < 7) begin
                add(4'hA, 4'h0, 1'b1, 1'b0, 32'hD000_0000 + 32'(k), 1'b1, 1'b0, bit_of(gn), bit_of(g),
                    1'b0, 32'hD000_0000 + 32'(k), a_of(gn), 1'b0, w_of(gn), "fair_c");
            end else begin
                add(4'h0, 4'h0, 1'b1, 1'b0, 32'hD000_0000 + 32'(k), 1'b0, 1'b0, 4'h0, bit_of(g),
                    1'b0, 32'hD000_0000 + 32'(k), a_of(g), 1'b0, w_of(g), "fair_c");
            end
        end

        // ---- Slow slave: pready low for 3 ACCESS cycles, then high with pslverr ----
        add(4'h4, 4'h4, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 4'h4, 4'h0, 1'b0, 32'h0, a_of(2), 1'b1, w_of(2), "slow_g");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(2), 1'b1, w_of(2), "slow_s");
        for (int k = 0; k < 3; k++) begin
            add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(2), 1'b1, w_of(2), "slow_w");
        end
        add(4'h0, 4'h0, 1'b1, 1'b1, 32'h99, 1'b0, 1'b0, 4'h0, 4'h4, 1'b1, 32'h0, a_of(2), 1'b1, w_of(2), "slow_done");

        // ---- Timeout (8 cycles): requester 0 read with pready stuck low, then requester 3 served ----
        add(4'h1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 32'h0, a_of(0), 1'b0, w_of(0), "to_g");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(0), 1'b0, w_of(0), "to_s");
        for (int k = 0; k < 7; k++) begin
            add(4'h0, 4'h0, 1'b0, 1'b0, 32'hBAD0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0, a_of(0), 1'b0, w_of(0), "to_w");
        end
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'hBAD0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b1, 32'h0,    a_of(0), 1'b0, w_of(0), "to_abort");
        add(4'h8, 4'h0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 4'h8, 4'h0, 1'b0, 32'h0,    a_of(3), 1'b0, w_of(3), "to_next_g");
        add(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 32'h0,    a_of(3), 1'b0, w_of(3), "to_next_s");
        add(4'h0, 4'h0, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 32'h1234, a_of(3), 1'b0, w_of(3), "to_next_done");

        // ---- Apply the table ----
        foreach (vecs[i]) begin
            req_valid = vecs[i].rv;
            req_write = vecs[i].wr;
            pready    = vecs[i].rdy;
            pslverr   = vecs[i].serr;
            prdata    = vecs[i].prd;
            tick();
            check({vecs[i].name, "/psel"},      32'(psel),      32'(vecs[i].e_psel));
            check({vecs[i].name, "/penable"},   32'(penable),   32'(vecs[i].e_pen));
            check({vecs[i].name, "/req_ready"}, 32'(req_ready), 32'(vecs[i].e_rr));
            check({vecs[i].name, "/rsp_valid"}, 32'(rsp_valid), 32'(vecs[i].e_rsp));
            check({vecs[i].name, "/paddr"},     paddr,          vecs[i].e_paddr);
            check({vecs[i].name, "/pwrite"},    32'(pwrite),    32'(vecs[i].e_pwrite));
            check({vecs[i].name, "/pwdata"},    pwdata,         vecs[i].e_pwdata);
            if (vecs[i].e_rsp != 4'h0) begin
                check({vecs[i].name, "/rsp_rdata"}, rsp_rdata,    vecs[i].e_rdata);
                check({vecs[i].name, "/rsp_err"},   32'(rsp_err), 32'(vecs[i].e_err));
                $display("rsp %-14s rsp_valid=%b rdata=0x%08h err=%b", vecs[i].name, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        req_valid = '0;
        req_write = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // ---- Reset pulsed during ACCESS: requester 1 in flight, ptr currently 0 -> 2 ----
        req_valid = 4'h2;
        tick();
        check("arst/grant_rr",  32'(req_ready), 32'h2);
        check("arst/grant_adr", paddr,          a_of(1));
        req_valid = 4'h0;
        tick();
        check("arst/access_pen", 32'(penable), 32'd1);
        #2;
        presetn = 1'b0;
        #1;
        check("arst/async_psel",    32'(psel),      32'd0);
        check("arst/async_penable", 32'(penable),   32'd0);
        check("arst/async_paddr",   paddr,          32'd0);
        check("arst/async_rsp",     32'(rsp_valid), 32'd0);
        pready = 1'b1;
        tick();
        check("arst/held_rsp",  32'(rsp_valid), 32'd0);
        check("arst/held_psel", 32'(psel),      32'd0);
        presetn = 1'b1;
        pready  = 1'b0;
        tick();
        check("arst/after_rsp",  32'(rsp_valid), 32'd0);
        check("arst/after_psel", 32'(psel),      32'd0);
        // ptr restarted at 0, so of {1,3} requester 1 wins.
        req_valid = 4'hA;
        tick();
        check("arst/regrant_rr",  32'(req_ready), 32'h2);
        check("arst/regrant_adr", paddr,          a_of(1));
        req_valid = 4'h0;
        tick();
        check("arst/regrant_pen", 32'(penable), 32'd1);
        pready = 1'b1;
        prdata = 32'h0000_0077;
        tick();
        pready = 1'b0;
        check("arst/done_rsp",   32'(rsp_valid), 32'h2);
        check("arst/done_rdata", rsp_rdata,      32'h0000_0077);
        check("arst/done_err",   32'(rsp_err),   32'd0);
        $display("rsp %-14s rsp_valid=%b rdata=0x%08h err=%b", "arst_done", rsp_valid, rsp_rdata, rsp_err);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
